// File: rtl/cpu_trace_pkg.sv
// Shared types and width helpers for the CPU execution-trace recorder.
// A trace entry is packed as {cycle, pc, regs}, with the cycle stamp in the MSBs.
package cpu_trace_pkg;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } halt_state_t;

    // Ceiling log2, usable in constant expressions (clog2(1) = 0).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    function automatic int entry_w(input int cyc_w, input int pc_w,
                                   input int nch, input int data_w);
        return cyc_w + pc_w + nch * data_w;
    endfunction

    function automatic int pc_lsb(input int nch, input int data_w);
        return nch * data_w;
    endfunction

    function automatic int cyc_lsb(input int pc_w, input int nch, input int data_w);
        return pc_w + nch * data_w;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Generic synchronous first-word-fall-through FIFO.
// The pointers carry one extra wrap bit, and the occupancy count is held in a register.
module trace_fifo
    import cpu_trace_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          i_rst,
    input  logic                          i_push,
    input  logic [WIDTH-1:0]              i_wdata,
    input  logic                          i_ready,
    output logic                          o_valid,
    output logic [WIDTH-1:0]              o_rdata,
    output logic [clog2(DEPTH+1)-1:0]     o_count,
    output logic                          o_full,
    output logic                          o_pop
);
    localparam int AW = clog2(DEPTH);
    localparam int CW = clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_wr;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = i_ready && !w_empty;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign w_wr    = i_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (!i_rst && w_wr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_valid = !w_empty;
    assign o_rdata = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign o_count = r_count;
    assign o_full  = w_full;
    assign o_pop   = w_pop;

endmodule

// File: rtl/cpu_trace_buffer.sv
// Execution-trace recorder: stores a timestamped {pc, regs} entry whenever the
// sampled core state changes, and flags a core whose PC stays stuck.
module cpu_trace_buffer
    import cpu_trace_pkg::*;
#(
    parameter int PC_W        = 16,
    parameter int DATA_W      = 16,
    parameter int NCH         = 1,
    parameter int DEPTH       = 16,
    parameter int HALT_CYCLES = 4,
    parameter int CYC_W       = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [PC_W-1:0]               pc,
    input  logic [NCH*DATA_W-1:0]         regs,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CYC_W-1:0]              out_cycle,
    output logic [PC_W-1:0]               out_pc,
    output logic [NCH*DATA_W-1:0]         out_regs,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic                          overflow,
    output logic                          halted
);
    localparam int RW    = NCH * DATA_W;
    localparam int EW    = entry_w(CYC_W, PC_W, NCH, DATA_W);
    localparam int PC_LO = pc_lsb(NCH, DATA_W);
    localparam int CY_LO = cyc_lsb(PC_W, NCH, DATA_W);
    localparam int SW    = clog2(HALT_CYCLES + 1);

    logic [CYC_W-1:0] r_cyc;
    logic [PC_W-1:0]  r_pc_q;
    logic [RW-1:0]    r_regs_q;
    logic             r_have_prev;
    logic             r_overflow;
    logic [SW-1:0]    r_stall_cnt;
    halt_state_t      r_state;
    logic             r_halted;

    logic             w_pc_same;
    logic             w_changed;
    logic             w_capture;
    logic [EW-1:0]    w_entry;
    logic [EW-1:0]    w_head;
    logic             w_full;
    logic             w_pop;
    logic             w_drop;

    assign w_pc_same = (pc == r_pc_q);
    assign w_changed = !r_have_prev || !w_pc_same || (regs != r_regs_q);
    assign w_capture = en && !r_halted && w_changed;
    assign w_entry   = {r_cyc, pc, regs};
    assign w_drop    = w_capture && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cyc       <= '0;
            r_pc_q      <= '0;
            r_regs_q    <= '0;
            r_have_prev <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_cyc <= r_cyc + CYC_W'(1);
            if (en) begin
                r_pc_q      <= pc;
                r_regs_q    <= regs;
                r_have_prev <= 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Halt FSM: the transition fires on the comparison that brings stall_cnt to HALT_CYCLES.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_halted    <= 1'b0;
            r_stall_cnt <= '0;
        end else if (en) begin
            if (r_have_prev && w_pc_same) begin
                if (r_stall_cnt != SW'(HALT_CYCLES)) begin
                    r_stall_cnt <= r_stall_cnt + SW'(1);
                end
                if (r_state == ST_RUN && r_stall_cnt == SW'(HALT_CYCLES - 1)) begin
                    r_state  <= ST_HALTED;
                    r_halted <= 1'b1;
                end
            end else if (!w_pc_same) begin
                r_stall_cnt <= '0;
            end
        end
    end

    trace_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .i_rst   (rst),
        .i_push  (w_capture),
        .i_wdata (w_entry),
        .i_ready (out_ready),
        .o_valid (out_valid),
        .o_rdata (w_head),
        .o_count (count),
        .o_full  (w_full),
        .o_pop   (w_pop)
    );

    assign out_cycle = w_head[CY_LO +: CYC_W];
    assign out_pc    = w_head[PC_LO +: PC_W];
    assign out_regs  = w_head[0 +: RW];
    assign overflow  = r_overflow;
    assign halted    = r_halted;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Scoreboard bench for cpu_trace_buffer: expected entries are queued as stimulus
// is driven, then popped and compared whenever the DUT hands over its head entry.
module tb_cpu_trace_buffer;
    localparam int PC_W        = 16;
    localparam int DATA_W      = 16;
    localparam int NCH         = 2;
    localparam int DEPTH       = 16;
    localparam int HALT_CYCLES = 4;
    localparam int CYC_W       = 16;
    localparam int RW          = NCH * DATA_W;
    localparam int EW          = CYC_W + PC_W + RW;
    localparam int CNTW        = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic [PC_W-1:0]   pc = '0;
    logic [RW-1:0]     regs = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [CYC_W-1:0]  out_cycle;
    logic [PC_W-1:0]   out_pc;
    logic [RW-1:0]     out_regs;
    logic [CNTW-1:0]   count;
    logic              overflow;
    logic              halted;

    logic [EW-1:0]     exp_q[$];
    logic [EW-1:0]     exp_e;
    logic [CYC_W-1:0]  tb_cyc;
    int                checks = 0;
    int                failures = 0;

    always #5 clk = ~clk;

    cpu_trace_buffer #(
        .PC_W        (PC_W),
        .DATA_W      (DATA_W),
        .NCH         (NCH),
        .DEPTH       (DEPTH),
        .HALT_CYCLES (HALT_CYCLES),
        .CYC_W       (CYC_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .pc        (pc),
        .regs      (regs),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_cycle (out_cycle),
        .out_pc    (out_pc),
        .out_regs  (out_regs),
        .count     (count),
        .overflow  (overflow),
        .halted    (halted)
    );

    // Reference timestamp: free-running cycle count since the last reset edge.
    always @(posedge clk) begin
        if (rst) tb_cyc <= '0;
        else     tb_cyc <= tb_cyc + 1'b1;
    end

    // Scoreboard consumer: every accepted head must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL entry_unexpected got cyc=%h pc=%h regs=%h required none",
                         out_cycle, out_pc, out_regs);
            end else begin
                exp_e = exp_q.pop_front();
                if ({out_cycle, out_pc, out_regs} !== exp_e) begin
                    failures++;
                    $display("FAIL entry got cyc=%h pc=%h regs=%h required cyc=%h pc=%h regs=%h",
                             out_cycle, out_pc, out_regs,
                             exp_e[EW-1 -: CYC_W], exp_e[RW +: PC_W], exp_e[0 +: RW]);
                end else begin
                    $display("pop cyc=%h pc=%h regs=%h", out_cycle, out_pc, out_regs);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic sample(input logic [PC_W-1:0] p, input logic [RW-1:0] r, input bit expect_capture);
        en = 1'b1;
        pc = p;
        regs = r;
        if (expect_capture) exp_q.push_back({tb_cyc, p, r});
        tick();
    endtask

    task automatic drain_all(input int limit);
        int n;
        n = 0;
        en = 1'b0;
        out_ready = 1'b1;
        while (out_valid && n < limit) begin
            tick();
            n++;
        end
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain_timeout out_valid=%b required 0 after %0d cycles", out_valid, n);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_leftover expected_entries_left=%0d required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b required 0", out_valid); end
        checks++; if (count !== '0) begin failures++; $display("FAIL reset_count got %0d required 0", count); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got %b required 0", overflow); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got %b required 0", halted); end
        checks++; if (out_cycle !== '0) begin failures++; $display("FAIL reset_cycle got %h required 0", out_cycle); end
        checks++; if (out_pc !== '0) begin failures++; $display("FAIL reset_pc got %h required 0", out_pc); end
        checks++; if (out_regs !== '0) begin failures++; $display("FAIL reset_regs got %h required 0", out_regs); end
    endtask

    task automatic test_single_capture();
        en = 1'b0;
        tick();
        sample(16'h0000, '0, 1'b1);
        en = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got %b required 1", out_valid); end
        checks++; if (count !== CNTW'(1)) begin failures++; $display("FAIL single_count got %0d required 1", count); end
        checks++; if (out_cycle !== CYC_W'(1)) begin failures++; $display("FAIL single_cycle got %h required 1", out_cycle); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || count !== '0) begin
            failures++; $display("FAIL single_drained got valid=%b count=%0d required 0/0", out_valid, count);
        end
    endtask

    task automatic test_sequence();
        int max_cnt;
        max_cnt = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample(PC_W'(16'h0010 + i), {16'h1234, 16'h5678}, 1'b1);
            if (int'(count) > max_cnt) max_cnt = int'(count);
        end
        en = 1'b0;
        tick();
        out_ready = 1'b0;
        checks++; if (max_cnt > 1) begin failures++; $display("FAIL seq_max_count got %0d required <=1", max_cnt); end
        checks++; if (count !== '0 || exp_q.size() != 0) begin
            failures++; $display("FAIL seq_drained got count=%0d pending=%0d required 0/0", count, exp_q.size());
        end
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            sample(PC_W'(16'h0100 + i), {16'h00AA, 16'h0055}, (i < DEPTH));
        end
        en = 1'b0;
        checks++; if (count !== CNTW'(DEPTH)) begin failures++; $display("FAIL ovf_count got %0d required %0d", count, DEPTH); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got %b required 1", overflow); end
        checks++; if (out_pc !== 16'h0100) begin failures++; $display("FAIL ovf_head_pc got %h required 0100", out_pc); end
        drain_all(40);
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got %b required 1", overflow); end
    endtask

    task automatic test_push_pop_full();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            sample(PC_W'(16'h0200 + i), {16'h0F0F, 16'h0001}, 1'b1);
        end
        en = 1'b0;
        checks++; if (count !== CNTW'(DEPTH)) begin failures++; $display("FAIL full_count got %0d required %0d", count, DEPTH); end
        out_ready = 1'b1;
        sample(16'h0300, {16'h0F0F, 16'h0001}, 1'b1);
        out_ready = 1'b0;
        en = 1'b0;
        checks++; if (count !== CNTW'(DEPTH)) begin failures++; $display("FAIL pushpop_count got %0d required %0d", count, DEPTH); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL pushpop_overflow got %b required 0", overflow); end
        checks++; if (out_pc !== 16'h0201) begin failures++; $display("FAIL pushpop_head got %h required 0201", out_pc); end
        drain_all(40);
    endtask

    task automatic test_halt();
        out_ready = 1'b0;
        sample(16'h0007, {16'hAAAA, 16'h0001}, 1'b1);
        for (int i = 0; i < HALT_CYCLES - 1; i++) begin
            sample(16'h0007, {16'hAAAA, 16'h0001}, 1'b0);
        end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL halt_early got %b required 0", halted); end
        sample(16'h0007, {16'hAAAA, 16'h0001}, 1'b0);
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_set got %b required 1", halted); end
        sample(16'h0007, {16'hAAAA, 16'hFFFB}, 1'b0);
        sample(16'h0007, {16'hAAAA, 16'hFFFB}, 1'b0);
        sample(16'h0008, {16'hAAAA, 16'hFFFB}, 1'b0);
        en = 1'b0;
        tick();
        checks++; if (count !== CNTW'(1)) begin failures++; $display("FAIL halt_no_capture count got %0d required 1", count); end
        drain_all(10);
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_sticky got %b required 1", halted); end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        for (int i = 0; i < 21; i++) begin
            sample(PC_W'(16'h0400 + i), {16'h4444, 16'h0004}, (i < DEPTH));
        end
        for (int i = 0; i < HALT_CYCLES; i++) begin
            sample(16'h0414, {16'h4444, 16'h0004}, 1'b0);
        end
        en = 1'b0;
        checks++; if (overflow !== 1'b1 || halted !== 1'b1) begin
            failures++; $display("FAIL mid_pre_flags got ovf=%b halt=%b required 1/1", overflow, halted);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) tick();
        out_ready = 1'b0;
        checks++; if (count !== CNTW'(5)) begin failures++; $display("FAIL mid_count got %0d required 5", count); end
        out_ready = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        checks++; if (count !== '0) begin failures++; $display("FAIL mid_rst_count got %0d required 0", count); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got %b required 0", out_valid); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL mid_rst_halted got %b required 0", halted); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL mid_rst_overflow got %b required 0", overflow); end
        sample(16'h0055, '0, 1'b1);
        en = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_cycle !== '0) begin
            failures++; $display("FAIL mid_rst_cyc got valid=%b cyc=%h required 1/0000", out_valid, out_cycle);
        end
        drain_all(10);
    endtask

    initial begin
        test_reset();
        test_single_capture();
        test_sequence();
        test_overflow();
        test_push_pop_full();
        test_halt();
        test_reset_mid_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cpu_trace_buffer.md
# cpu_trace_buffer

Parametrised, synthesizable execution-trace recorder for the 16-bit MIPS core. It samples the program counter and NCH architectural register taps every enabled cycle and stores a timestamped entry whenever any of them changes. Entries go into an on-chip FIFO that is drained through a valid/ready port. It also detects a halted core (PC stuck) and sets a sticky flag. It sits beside `cpu_behav` and replaces per-cycle console printing with a bounded hardware trace usable both in simulation and on the board.

## Interface
- `PC_W`, 16, program-counter width
- `DATA_W`, 16, width of one register tap
- `NCH`, 1, number of register taps (1..8)
- `DEPTH`, 16, FIFO entries; power of two, ≥2
- `HALT_CYCLES`, 4, consecutive equal-PC comparisons that declare halt (≥1)
- `CYC_W`, 16, timestamp width

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `en`  in  1  sampling enable
- `pc`  in  PC_W  core program counter
- `regs`  in  NCH*DATA_W  register taps; channel k at bits [k*DATA_W +: DATA_W]
- `out_valid`  out  1  FIFO head valid
- `out_ready`  in  1  consumer accepts head
- `out_cycle`  out  CYC_W  head timestamp
- `out_pc`  out  PC_W  head PC
- `out_regs`  out  NCH*DATA_W  head register values
- `count`  out  $clog2(DEPTH+1)  current occupancy
- `overflow`  out  1  sticky; an entry was dropped
- `halted`  out  1  sticky; halt detected

## Operation
- Cycle counter `cyc`: reset 0. Increments every clock regardless of `en`. Wraps 2^CYC_W−1 → 0.
- Previous-sample registers `pc_q` and `regs_q`, plus flag `have_prev`:
  - all reset to 0.
  - loaded from the inputs on every `en` cycle; `have_prev` set to 1 at the same time.
- Capture condition: `en && !halted && (!have_prev || pc!=pc_q || regs!=regs_q)`.
- Captured entry: {`cyc`, `pc`, `regs`} as they are during the capture cycle.
- Push when FIFO is full:
  - with no pop in the same cycle → entry dropped and `overflow` set.
  - with a pop in the same cycle → push accepted, `count` unchanged, no overflow.
- Pop: `out_valid && out_ready`. `out_ready` while empty has no effect.
- Halt detection uses `stall_cnt`, width $clog2(HALT_CYCLES+1), reset 0:
  - on `en && have_prev && pc==pc_q`: saturating increment.
  - on `en && pc!=pc_q`: clear to 0.
  - `halted` is set on the edge where `stall_cnt` reaches HALT_CYCLES.
- After halt:
  - capture stops.
  - draining continues normally.
  - only `rst` clears `halted` and `overflow`.
- When `en`=0, no state changes except `cyc` and FIFO pops.
- Reset mid-operation: the FIFO is emptied, all flags are cleared, and any in-flight push or pop is discarded.

## Timing
- Reset values:
  - `out_valid`=0, `count`=0, `overflow`=0, `halted`=0.
  - `out_cycle`, `out_pc`, `out_regs` = 0.
- Capture latency is 1 cycle: an entry captured in cycle t is written at the end of t. If the FIFO was empty, `out_valid`=1 in cycle t+1.
- First-word-fall-through: head fields are valid combinationally from storage whenever `out_valid`=1. Fields are held while `out_ready`=0.
- A pop in cycle t shows the next head, or `out_valid`=0, in cycle t+1.
- `count` updates on the same edge as the push/pop.
- `halted` is visible the cycle after the HALT_CYCLES-th equal comparison. The sample from that comparison cycle itself is not captured (PC and regs are unchanged anyway).

## Structure
- Package `cpu_trace_pkg`:
  - entry width constant/function (CYC_W+PC_W+NCH*DATA_W).
  - packed entry layout: cycle at MSBs, then pc, then regs.
  - helper `clog2`.
- Sub-module `trace_fifo`: generic sync FIFO (WIDTH, DEPTH), FWFT, registered `count`, one-bit-extended wrap pointers.
- Top-level content: change detection, cycle counter, halt FSM (two states, RUN and HALTED), overflow flag.

## Test plan
- Reset, then `en`=1, pc=0x0000, regs=0 for 1 cycle → exactly one entry {cyc=1, pc=0, regs=0}. `out_valid` rises the following cycle.
- PC sequence 0,1,2,3 with regs constant, `out_ready`=1 → four entries with consecutive cycles and pc 0..3. `count` never exceeds 1.
- `out_ready`=0 for 20 distinct PCs with DEPTH=16 → `count`=16, `overflow`=1. Drain returns the first 16 PCs in order.
- PC held at 0x0007 with HALT_CYCLES=4 → `halted`=1 after the 4th equal comparison. A later reg change (reg0=−5) produces no entry.
- Full FIFO with push and pop in the same cycle → `count` stays 16, `overflow` stays 0, the new entry appears at the tail.
- Assert `rst` mid-drain with `count`=5 → next cycle `count`=0, `out_valid`=0, `halted`=0, `overflow`=0, `cyc`=0.
